pong_match_ctrl: RTL

Match-flow controller for the Pong datapath. It sequences the ball and paddle blocks through reset, serve, rally, point and game-over phases, keeps both scores and a rally speed level, and picks the winner. It sits above the ball mover, the paddle movers and the right-paddle AI, and drives their enables and reload strobes from one frame-tick domain.

---
 rtl/pong_match_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match-flow sequencer for the Pong datapath.
// Tracks scores, rally speed level and winner; drives motion enables and position reloads.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE      = 7,
  parameter int unsigned SERVE_FRAMES   = 60,
  parameter int unsigned POINT_FRAMES   = 90,
  parameter int unsigned HITS_PER_LEVEL = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       ball_out_l,
  input  logic       ball_out_r,
  input  logic       paddle_l,
  input  logic       paddle_r,
  output logic       ld_pos,
  output logic       ball_en,
  output logic       paddle_en,
  output logic       serve_dir,
  output logic [1:0] speed_lvl,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam int unsigned MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int unsigned FW         = $clog2(MAX_FRAMES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SERVE = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_POINT = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [3:0]    score_l_q, score_l_d;
  logic [3:0]    score_r_q, score_r_d;
  logic [1:0]    winner_q, winner_d;
  logic          serve_dir_q, serve_dir_d;
  logic [1:0]    speed_q, speed_d;
  logic [7:0]    hits_q, hits_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic          start_q;
  logic          start_p;
  logic          l_won, r_won;
  logic [31:0]   lvl_full;

  // Next-state, score and counter logic; pause freezes SERVE/PLAY/POINT entirely
  always_comb begin
    state_d     = state_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    winner_d    = winner_q;
    serve_dir_d = serve_dir_q;
    hits_d      = hits_q;
    cnt_d       = cnt_q;
    start_p     = start & ~start_q;
    l_won       = (score_l_q == 4'(WIN_SCORE));
    r_won       = (score_r_q == 4'(WIN_SCORE));

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_p) begin
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          winner_d    = 2'b00;
          serve_dir_d = 1'b1;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        hits_d  = 8'd0;
        cnt_d   = FW'(SERVE_FRAMES);
        state_d = S_SERVE;
      end
      S_SERVE: begin
        if (!pause && tick) begin
          cnt_d = cnt_q - FW'(1);
          if (cnt_q == FW'(1)) state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (!pause) begin
          if ((paddle_l || paddle_r) && hits_q != 8'hFF) hits_d = hits_q + 8'd1;
          // Simultaneous goals at both ends are treated as a glitch and dropped
          if (ball_out_l && !ball_out_r) begin
            score_r_d   = score_r_q + 4'd1;
            serve_dir_d = 1'b0;
            cnt_d       = FW'(POINT_FRAMES);
            state_d     = S_POINT;
          end else if (ball_out_r && !ball_out_l) begin
            score_l_d   = score_l_q + 4'd1;
            serve_dir_d = 1'b1;
            cnt_d       = FW'(POINT_FRAMES);
            state_d     = S_POINT;
          end
        end
      end
      S_POINT: begin
        if (!pause) begin
          if (l_won || r_won) begin
            winner_d = l_won ? 2'b01 : 2'b10;
            state_d  = S_OVER;
          end else if (tick) begin
            cnt_d = cnt_q - FW'(1);
            if (cnt_q == FW'(1)) state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    lvl_full = 32'(hits_d) / HITS_PER_LEVEL;
    speed_d  = (lvl_full >= 32'd3) ? 2'd3 : 2'(lvl_full);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      winner_q    <= 2'b00;
      serve_dir_q <= 1'b1;
      speed_q     <= 2'd0;
      hits_q      <= 8'd0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      winner_q    <= winner_d;
      serve_dir_q <= serve_dir_d;
      speed_q     <= speed_d;
      hits_q      <= hits_d;
      cnt_q       <= cnt_d;
      start_q     <= start;
    end
  end

  // Moore decode from the state register, gated by pause
  assign ld_pos    = (state_q == S_LOAD);
  assign ball_en   = (state_q == S_PLAY) && !pause;
  assign paddle_en = ((state_q == S_SERVE) || (state_q == S_PLAY)) && !pause;

  assign serve_dir = serve_dir_q;
  assign speed_lvl = speed_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign winner    = winner_q;
  assign state     = state_q;

endmodule
